sap_controller_sequencer: RTL

Control sequencer for the SAP-1 datapath.
- Steps a six-phase T-state ring (T1–T6) and decodes the instruction-register opcode into the per-phase control word.
- The control word drives the program counter (increment, output enable), MAR, RAM, IR, accumulator, ALU, B register and output register.
- Sits beside the program counter on the shared W-bus; it is the only source of bus-enable and load strobes.
- Provides run/idle gating and a latched halt.

---
 rtl/sap_pkg.sv | 43 ++++
 rtl/sap_ring_counter.sv | 34 +++
 rtl/sap_controller_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, sequencer state encoding and control-word bit map.
package sap_pkg;

  localparam int unsigned SAP_OPCODE_W = 4;
  localparam int unsigned SAP_NUM_T    = 6;
  localparam int unsigned CW_W         = 12;

  localparam logic [SAP_OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [SAP_OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [SAP_OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [SAP_OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [SAP_OPCODE_W-1:0] OP_HLT = 4'b1111;

  // Top-level mode; the phase within RUN lives in the ring counter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // One-hot ring positions.
  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T5 = 4;
  localparam int unsigned T6 = 5;

  // Control-word bit indices, shared with the datapath top.
  localparam int unsigned CW_PC_INC     = 0;
  localparam int unsigned CW_PC_OUT_EN  = 1;
  localparam int unsigned CW_MAR_LOAD   = 2;
  localparam int unsigned CW_RAM_OUT_EN = 3;
  localparam int unsigned CW_IR_LOAD    = 4;
  localparam int unsigned CW_IR_OUT_EN  = 5;
  localparam int unsigned CW_ACC_LOAD   = 6;
  localparam int unsigned CW_ACC_OUT_EN = 7;
  localparam int unsigned CW_B_LOAD     = 8;
  localparam int unsigned CW_OUT_LOAD   = 9;
  localparam int unsigned CW_ALU_SUB    = 10;
  localparam int unsigned CW_ALU_OUT_EN = 11;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: rotates when enabled, loads T1 synchronously, clears asynchronously.
module sap_ring_counter #(
  parameter int unsigned NUM_T = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en_i,
  input  logic             load_i,
  output logic [NUM_T-1:0] ring_o
);

  logic [NUM_T-1:0] ring_q;
  logic [NUM_T-1:0] ring_d;

  always_comb begin
    ring_d = ring_q;
    if (load_i) begin
      ring_d = NUM_T'(1);
    end else if (en_i) begin
      ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control sequencer: run/idle/halt mode FSM around the T-state ring plus opcode decode.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned NUM_T    = 6
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [NUM_T-1:0]    t_state,
  output logic                halted,
  output logic                pc_inc,
  output logic                pc_out_en,
  output logic                mar_load,
  output logic                ram_out_en,
  output logic                ir_load,
  output logic                ir_out_en,
  output logic                acc_load,
  output logic                acc_out_en,
  output logic                b_load,
  output logic                out_load,
  output logic                alu_sub,
  output logic                alu_out_en
);

  state_e           state_q;
  state_e           state_d;
  logic [NUM_T-1:0] ring;
  logic             ring_en;
  logic             ring_load;
  logic             is_hlt;
  logic [CW_W-1:0]  cw_c;

  sap_ring_counter #(.NUM_T(NUM_T)) u_ring (
    .clk    (clk),
    .clr_n  (clr_n),
    .en_i   (ring_en),
    .load_i (ring_load),
    .ring_o (ring)
  );

  assign is_hlt = (opcode == OPCODE_W'(OP_HLT));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // T6 reloads T1 directly so back-to-back instructions have no bubble.
  always_comb begin
    state_d   = state_q;
    ring_en   = 1'b0;
    ring_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d   = ST_RUN;
          ring_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (ring[T4] && is_hlt) begin
          state_d = ST_HALT;
        end else if (ring[T6]) begin
          if (run) begin
            ring_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ring_en = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cw_c = '0;
    if (state_q == ST_RUN) begin
      if (ring[T1]) begin
        cw_c[CW_PC_OUT_EN] = 1'b1;
        cw_c[CW_MAR_LOAD]  = 1'b1;
      end
      if (ring[T2]) begin
        cw_c[CW_PC_INC] = 1'b1;
      end
      if (ring[T3]) begin
        cw_c[CW_RAM_OUT_EN] = 1'b1;
        cw_c[CW_IR_LOAD]    = 1'b1;
      end
      if (ring[T4]) begin
        case (opcode)
          OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
            cw_c[CW_IR_OUT_EN] = 1'b1;
            cw_c[CW_MAR_LOAD]  = 1'b1;
          end
          OPCODE_W'(OP_OUT): begin
            cw_c[CW_ACC_OUT_EN] = 1'b1;
            cw_c[CW_OUT_LOAD]   = 1'b1;
          end
          default: ;
        endcase
      end
      if (ring[T5]) begin
        case (opcode)
          OPCODE_W'(OP_LDA): begin
            cw_c[CW_RAM_OUT_EN] = 1'b1;
            cw_c[CW_ACC_LOAD]   = 1'b1;
          end
          OPCODE_W'(OP_ADD): begin
            cw_c[CW_RAM_OUT_EN] = 1'b1;
            cw_c[CW_B_LOAD]     = 1'b1;
          end
          OPCODE_W'(OP_SUB): begin
            cw_c[CW_RAM_OUT_EN] = 1'b1;
            cw_c[CW_B_LOAD]     = 1'b1;
            cw_c[CW_ALU_SUB]    = 1'b1;
          end
          default: ;
        endcase
      end
      if (ring[T6]) begin
        case (opcode)
          OPCODE_W'(OP_ADD): begin
            cw_c[CW_ALU_OUT_EN] = 1'b1;
            cw_c[CW_ACC_LOAD]   = 1'b1;
          end
          OPCODE_W'(OP_SUB): begin
            cw_c[CW_ALU_OUT_EN] = 1'b1;
            cw_c[CW_ACC_LOAD]   = 1'b1;
            cw_c[CW_ALU_SUB]    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign t_state    = (state_q == ST_RUN) ? ring : '0;
  assign halted     = (state_q == ST_HALT);
  assign pc_inc     = cw_c[CW_PC_INC];
  assign pc_out_en  = cw_c[CW_PC_OUT_EN];
  assign mar_load   = cw_c[CW_MAR_LOAD];
  assign ram_out_en = cw_c[CW_RAM_OUT_EN];
  assign ir_load    = cw_c[CW_IR_LOAD];
  assign ir_out_en  = cw_c[CW_IR_OUT_EN];
  assign acc_load   = cw_c[CW_ACC_LOAD];
  assign acc_out_en = cw_c[CW_ACC_OUT_EN];
  assign b_load     = cw_c[CW_B_LOAD];
  assign out_load   = cw_c[CW_OUT_LOAD];
  assign alu_sub    = cw_c[CW_ALU_SUB];
  assign alu_out_en = cw_c[CW_ALU_OUT_EN];

endmodule
